// File: rtl/div4bs.sv
// Sequential restoring divider: one quotient bit per clock, start/busy/done handshake.
// A zero divisor completes in one cycle with q = all ones, r = x and div0 set.
module div4bs #(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [N-1:0] x,
    input  logic [N-1:0] y,
    output logic [N-1:0] q,
    output logic [N-1:0] r,
    output logic         busy,
    output logic         done,
    output logic         div0
);

    localparam int CW = $clog2(N);

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } state_t;

    state_t          state, state_next;
    logic            accept, last;
    logic [CW-1:0]   cnt;
    logic [N-1:0]    rem, rem_next;
    logic [N:0]      rem_shift, diff;
    logic [N-1:0]    dvd, quo, quo_next, ys;

    // NOTE: every always_comb output gets a default first so no path leaves it
    // unassigned; a missing default is how latches get inferred.
    always_comb begin
        state_next = state;
        accept     = 1'b0;
        last       = 1'b0;
        case (state)
            IDLE, DONE: begin
                state_next = IDLE;
                if (start) begin
                    accept     = 1'b1;
                    state_next = (y == '0) ? DONE : CALC;
                end
            end
            CALC: begin
                if (cnt == '0) begin
                    last       = 1'b1;
                    state_next = DONE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    assign busy = (state == CALC);
    assign done = (state == DONE);

    // The restored remainder is always below y, so N stored bits suffice;
    // only the shifted trial value needs the extra bit.
    always_comb begin
        rem_shift = {1'b0, rem, dvd[N-1]};
        rem_shift = {rem, dvd[N-1]};
        diff      = rem_shift - {1'b0, ys};
        if (diff[N]) begin
            rem_next = rem_shift[N-1:0];
            quo_next = {quo[N-2:0], 1'b0};
        end else begin
            rem_next = diff[N-1:0];
            quo_next = {quo[N-2:0], 1'b1};
        end
    end

    // NOTE: working registers carry no reset; they are always loaded on an
    // accepted start before being read, and only the visible results are cleared.
    always_ff @(posedge clk) begin
        if (accept) begin
            rem <= '0;
            quo <= '0;
            dvd <= x;
            ys  <= y;
            cnt <= CW'(N - 1);
        end else if (state == CALC) begin
            rem <= rem_next;
            quo <= quo_next;
            dvd <= {dvd[N-2:0], 1'b0};
            cnt <= cnt - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            q    <= '0;
            r    <= '0;
            div0 <= 1'b0;
        end else if (accept && (y == '0)) begin
            q    <= '1;
            r    <= x;
            div0 <= 1'b1;
        end else if (last) begin
            q    <= quo_next;
            r    <= rem_next;
            div0 <= 1'b0;
        end
    end

endmodule

// File: tb/tb_div4bs.sv
// Directed and exhaustive checks for div4bs (N=4): results, latency, handshake,
// start-ignored-in-CALC, back-to-back start and mid-operation reset.
module tb_div4bs;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic [3:0] x, y;
    logic [3:0] q, r;
    logic       busy, done, div0;

    int n_checks = 0;
    int n_errors = 0;

    div4bs #(.N(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .x     (x),
        .y     (y),
        .q     (q),
        .r     (r),
        .busy  (busy),
        .done  (done),
        .div0  (div0)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Shift-and-add product, standing in for the array multiplier.
    function automatic logic [7:0] mul4bj(input logic [3:0] a, input logic [3:0] b);
        logic [7:0] p;
        p = '0;
        for (int i = 0; i < 4; i++)
            if (b[i]) p = p + ({4'b0, a} << i);
        return p;
    endfunction

    // Called just after a rising edge; the following edge is the accepting edge E0.
    task automatic launch(input logic [3:0] a, input logic [3:0] b);
        x     = a;
        y     = b;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    // lat counts edges from E0 inclusive until done is seen; bounded.
    task automatic wait_done(input int lat0, output int lat, output int nbusy);
        lat   = lat0;
        nbusy = 0;
        while (!done && lat < 20) begin
            nbusy += int'(busy);
            @(posedge clk); #1;
            lat++;
        end
        check("busy_done_excl", {31'b0, busy & done}, 32'd0);
    endtask

    initial begin
        int lat, nbusy, seen;
        rst_n = 1'b0;
        start = 1'b0;
        x     = '0;
        y     = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_q", q, 0);
        check("rst_r", r, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_div0", div0, 0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // 13 / 3
        launch(4'd13, 4'd3);
        check("t1_busy_e0", busy, 1);
        wait_done(1, lat, nbusy);
        check("t1_lat", lat, 5);
        check("t1_nbusy", nbusy, 4);
        check("t1_q", q, 4);
        check("t1_r", r, 1);
        check("t1_div0", div0, 0);
        x = 4'd0; y = 4'd0;
        @(posedge clk); #1;
        check("t1_done_drop", done, 0);
        check("t1_q_hold", q, 4);
        check("t1_r_hold", r, 1);

        // 7 / 0 then 6 / 2
        launch(4'd7, 4'd0);
        check("t2_busy", busy, 0);
        wait_done(1, lat, nbusy);
        check("t2_lat", lat, 1);
        check("t2_q", q, 15);
        check("t2_r", r, 7);
        check("t2_div0", div0, 1);
        @(posedge clk); #1;
        check("t2_done_drop", done, 0);
        check("t2_busy_after", busy, 0);
        launch(4'd6, 4'd2);
        wait_done(1, lat, nbusy);
        check("t2b_lat", lat, 5);
        check("t2b_q", q, 3);
        check("t2b_r", r, 0);
        check("t2b_div0", div0, 0);
        @(posedge clk); #1;

        // 3 / 9 and 15 / 1
        launch(4'd3, 4'd9);
        wait_done(1, lat, nbusy);
        check("t3_lat", lat, 5);
        check("t3_q", q, 0);
        check("t3_r", r, 3);
        @(posedge clk); #1;
        launch(4'd15, 4'd1);
        wait_done(1, lat, nbusy);
        check("t3b_lat", lat, 5);
        check("t3b_q", q, 15);
        check("t3b_r", r, 0);
        @(posedge clk); #1;

        // 12 / 5 with a start pulse during CALC, then 9 / 2 back-to-back from DONE
        launch(4'd12, 4'd5);
        x = 4'd9; y = 4'd2; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; x = 4'd0; y = 4'd0;
        check("t4_busy_kept", busy, 1);
        wait_done(2, lat, nbusy);
        check("t4_lat", lat, 5);
        check("t4_q", q, 2);
        check("t4_r", r, 2);
        launch(4'd9, 4'd2);
        check("t4b_busy", busy, 1);
        check("t4b_done", done, 0);
        check("t4b_q_hold", q, 2);
        wait_done(1, lat, nbusy);
        check("t4b_lat", lat, 5);
        check("t4b_q", q, 4);
        check("t4b_r", r, 1);
        @(posedge clk); #1;

        // Reset during the second CALC cycle of 14 / 3
        launch(4'd14, 4'd3);
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        check("t5_q", q, 0);
        check("t5_r", r, 0);
        check("t5_busy", busy, 0);
        check("t5_done", done, 0);
        check("t5_div0", div0, 0);
        seen = 0;
        repeat (6) begin
            seen += int'(done);
            @(posedge clk); #1;
        end
        check("t5_no_done", seen, 0);
        launch(4'd14, 4'd3);
        wait_done(1, lat, nbusy);
        check("t5b_lat", lat, 5);
        check("t5b_q", q, 4);
        check("t5b_r", r, 2);
        @(posedge clk); #1;

        // All dividend/divisor pairs with a non-zero divisor
        for (int a = 0; a < 16; a++) begin
            for (int b = 1; b < 16; b++) begin
                launch(4'(a), 4'(b));
                wait_done(1, lat, nbusy);
                check("ex_lat", lat, 5);
                check("ex_inv", {24'b0, mul4bj(q, 4'(b))} + {28'b0, r}, a);
                check("ex_rlt", {31'b0, (r < 4'(b))}, 1);
                check("ex_div0", div0, 0);
            end
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
